// File: rtl/secuenciador_ciclo_if.sv
// Cycle-counter bus: the sequencer (master) drives enable and terminal length,
// and the counter (slave) returns its current count.
interface secuenciador_ciclo_if #(
   parameter int unsigned CONT_W = 5,
   parameter int unsigned T_W    = 6
);
   logic              EN_cuenta;
   logic [T_W-1:0]    tiempo;
   logic [CONT_W-1:0] cuenta;

   modport master (output EN_cuenta, output tiempo, input cuenta);
   modport slave  (input EN_cuenta, input tiempo, output cuenta);
endinterface

// File: rtl/secuenciador_ciclo.sv
// secuenciador_ciclo: drives the cycle counter through n periods of phase A then phase B.
// Optional shadow-count check of the counter is enabled by defining SECUENCIADOR_CICLO_CHECK_EN.
module secuenciador_ciclo #(
   parameter int unsigned CONT_W = 5,
   parameter int unsigned T_W    = 6,
   parameter int unsigned N_W    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 parar,
   input  logic [T_W-1:0]       tiempo_a,
   input  logic [T_W-1:0]       tiempo_b,
   input  logic [N_W-1:0]       n_ciclos,
   secuenciador_ciclo_if.master bus,
   output logic                 fase,
   output logic                 ocupado,
   output logic                 fin,
   output logic [N_W-1:0]       ciclo_actual,
   output logic                 error
);

   localparam int unsigned T_MAX = 1 << CONT_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FASE_A = 2'd1,
      FASE_B = 2'd2,
      FIN    = 2'd3
   } state_t;

   state_t         state;
   logic           en_q;
   logic [T_W-1:0] tiempo_q;
   logic [T_W-1:0] lat_a;
   logic [T_W-1:0] lat_b;
   logic [N_W-1:0] lat_n;
   logic           term_hit_c;
   logic           desajuste_c;

   // Lengths the counter cannot represent are forced into 1..2^CONT_W.
   function automatic logic [T_W-1:0] clamp_t(input logic [T_W-1:0] t);
      if (t == '0)
         return T_W'(1);
      else if (32'(t) > T_MAX)
         return T_W'(T_MAX);
      else
         return t;
   endfunction

   assign bus.EN_cuenta = en_q;
   assign bus.tiempo    = tiempo_q;
   assign term_hit_c    = (T_W'(bus.cuenta) == (tiempo_q - T_W'(1)));

`ifdef SECUENCIADOR_CICLO_CHECK_EN
   logic [CONT_W-1:0] sombra;
   logic              error_q;

   assign desajuste_c = en_q && (sombra != bus.cuenta);
   assign error       = error_q;

   // Shadow count restarts on every phase entry, exactly as the counter should.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sombra  <= '0;
         error_q <= 1'b0;
      end else begin
         if (!en_q || term_hit_c)
            sombra <= '0;
         else
            sombra <= sombra + CONT_W'(1);
         if (desajuste_c)
            error_q <= 1'b1;
      end
   end
`else
   assign desajuste_c = 1'b0;
   assign error       = 1'b0;
`endif

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         en_q         <= 1'b0;
         tiempo_q     <= '0;
         fase         <= 1'b0;
         ocupado      <= 1'b0;
         fin          <= 1'b0;
         ciclo_actual <= '0;
         lat_a        <= '0;
         lat_b        <= '0;
         lat_n        <= '0;
      end else begin
         fin <= 1'b0;
         if ((state != IDLE) && (parar || desajuste_c)) begin
            state        <= IDLE;
            en_q         <= 1'b0;
            tiempo_q     <= '0;
            fase         <= 1'b0;
            ocupado      <= 1'b0;
            ciclo_actual <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !parar && !error) begin
                     lat_a        <= clamp_t(tiempo_a);
                     lat_b        <= clamp_t(tiempo_b);
                     lat_n        <= n_ciclos;
                     ocupado      <= 1'b1;
                     ciclo_actual <= '0;
                     fase         <= 1'b0;
                     if (n_ciclos == '0) begin
                        state <= FIN;
                        fin   <= 1'b1;
                     end else begin
                        state    <= FASE_A;
                        en_q     <= 1'b1;
                        tiempo_q <= clamp_t(tiempo_a);
                     end
                  end
               end
               FASE_A: begin
                  if (term_hit_c) begin
                     state    <= FASE_B;
                     tiempo_q <= lat_b;
                     fase     <= 1'b1;
                  end
               end
               FASE_B: begin
                  if (term_hit_c) begin
                     if (ciclo_actual == (lat_n - N_W'(1))) begin
                        state    <= FIN;
                        en_q     <= 1'b0;
                        tiempo_q <= '0;
                        fase     <= 1'b0;
                        fin      <= 1'b1;
                     end else begin
                        state        <= FASE_A;
                        ciclo_actual <= ciclo_actual + N_W'(1);
                        tiempo_q     <= lat_a;
                        fase         <= 1'b0;
                     end
                  end
               end
               FIN: begin
                  state        <= IDLE;
                  ocupado      <= 1'b0;
                  ciclo_actual <= '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_secuenciador_ciclo.sv
// Directed bench for secuenciador_ciclo with a behavioural cycle counter on the bus.
// Shadow-check vectors are included when SECUENCIADOR_CICLO_CHECK_EN is defined.
module tb_secuenciador_ciclo;

   localparam int unsigned CONT_W = 5;
   localparam int unsigned T_W    = 6;
   localparam int unsigned N_W    = 4;

   logic              clk      = 1'b0;
   logic              reset    = 1'b0;
   logic              start    = 1'b0;
   logic              parar    = 1'b0;
   logic [T_W-1:0]    tiempo_a = '0;
   logic [T_W-1:0]    tiempo_b = '0;
   logic [N_W-1:0]    n_ciclos = '0;
   logic              fase;
   logic              ocupado;
   logic              fin;
   logic [N_W-1:0]    ciclo_actual;
   logic              error;
   logic [CONT_W-1:0] cnt_q;
   logic              atasco   = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   secuenciador_ciclo_if #(.CONT_W(CONT_W), .T_W(T_W)) bus ();

   secuenciador_ciclo #(.CONT_W(CONT_W), .T_W(T_W), .N_W(N_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .parar        (parar),
      .tiempo_a     (tiempo_a),
      .tiempo_b     (tiempo_b),
      .n_ciclos     (n_ciclos),
      .bus          (bus),
      .fase         (fase),
      .ocupado      (ocupado),
      .fin          (fin),
      .ciclo_actual (ciclo_actual),
      .error        (error)
   );

   always #5 clk = ~clk;

   // Downstream counter: counts 0..tiempo-1 while enabled, loads 0 otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (!bus.EN_cuenta)
         cnt_q <= '0;
      else if (T_W'(cnt_q) == (bus.tiempo - T_W'(1)))
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + CONT_W'(1);
   end

   assign bus.cuenta = atasco ? CONT_W'(2) : cnt_q;

   task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_vec++;
      if (obs !== esp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
      end
   endtask

   task automatic paso();
      @(posedge clk);
      #1;
   endtask

   // Start is sampled at the next edge; returns inside cycle 1.
   task automatic lanzar(input int ta, input int tb, input int n);
      tiempo_a = T_W'(ta);
      tiempo_b = T_W'(tb);
      n_ciclos = N_W'(n);
      start    = 1'b1;
      paso();
      start    = 1'b0;
   endtask

   task automatic medir(input int lim, output int fin_c, output int n_a, output int n_b,
                        output int max_a, output int sum_b, output int n_fin);
      fin_c = -1; n_a = 0; n_b = 0; max_a = 0; sum_b = 0; n_fin = 0;
      for (int c = 1; c <= lim; c++) begin
         if (bus.EN_cuenta && !fase) begin
            n_a++;
            if (int'(bus.cuenta) > max_a) max_a = int'(bus.cuenta);
         end
         if (bus.EN_cuenta && fase) begin
            n_b++;
            sum_b += int'(bus.cuenta);
         end
         if (fin) begin
            n_fin++;
            if (fin_c < 0) fin_c = c;
         end
         paso();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fase_tab[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
      int cnt_tab[10]  = '{0, 1, 2, 0, 1, 0, 1, 2, 0, 1};
      int fin_c, n_a, n_b, max_a, sum_b, n_fin;

      // Reset state
      #12;
      chequear("rst EN_cuenta", bus.EN_cuenta, 0);
      chequear("rst tiempo", bus.tiempo, 0);
      chequear("rst fase", fase, 0);
      chequear("rst ocupado", ocupado, 0);
      chequear("rst fin", fin, 0);
      chequear("rst ciclo", ciclo_actual, 0);
      chequear("rst error", error, 0);
      reset = 1'b1;
      paso();

      // Basic run tA=3 tB=2 n=2; tiempo_a change after latch must not matter
      lanzar(3, 2, 2);
      for (int c = 1; c <= 12; c++) begin
         if (c == 2) tiempo_a = T_W'(7);
         chequear($sformatf("basic en c%0d", c), bus.EN_cuenta, (c <= 10) ? 1 : 0);
         chequear($sformatf("basic fin c%0d", c), fin, (c == 11) ? 1 : 0);
         chequear($sformatf("basic ocupado c%0d", c), ocupado, (c <= 11) ? 1 : 0);
         chequear($sformatf("basic ciclo c%0d", c), ciclo_actual, (c >= 6 && c <= 11) ? 1 : 0);
         if (c <= 10) begin
            chequear($sformatf("basic fase c%0d", c), fase, fase_tab[c-1]);
            chequear($sformatf("basic cuenta c%0d", c), bus.cuenta, cnt_tab[c-1]);
         end
         paso();
      end

      // parar and start together in IDLE: parar wins
      tiempo_a = T_W'(3); tiempo_b = T_W'(3); n_ciclos = N_W'(1);
      start = 1'b1; parar = 1'b1;
      paso();
      start = 1'b0; parar = 1'b0;
      chequear("start+parar ocupado", ocupado, 0);
      chequear("start+parar en", bus.EN_cuenta, 0);
      paso();

      // Clamp: tA=0 -> 1, tB=40 -> 32
      lanzar(0, 40, 1);
      medir(40, fin_c, n_a, n_b, max_a, sum_b, n_fin);
      chequear("clamp len A", n_a, 1);
      chequear("clamp len B", n_b, 32);
      chequear("clamp fin cycle", fin_c, 34);
      chequear("clamp fin count", n_fin, 1);

      // n=0: immediate fin, counter never enabled
      lanzar(3, 3, 0);
      medir(5, fin_c, n_a, n_b, max_a, sum_b, n_fin);
      chequear("n0 fin cycle", fin_c, 1);
      chequear("n0 en cycles", n_a + n_b, 0);
      chequear("n0 fin count", n_fin, 1);

      // Boundary tA=32 tB=1
      lanzar(32, 1, 1);
      medir(40, fin_c, n_a, n_b, max_a, sum_b, n_fin);
      chequear("bound len A", n_a, 32);
      chequear("bound max cuenta A", max_a, 31);
      chequear("bound len B", n_b, 1);
      chequear("bound cuenta B", sum_b, 0);
      chequear("bound fin cycle", fin_c, 34);

      // Abort with an ignored second start
      lanzar(5, 5, 3);
      paso(); paso(); paso();
      start = 1'b1; tiempo_a = T_W'(9);
      paso();
      start = 1'b0;
      chequear("abort cuenta c5", bus.cuenta, 4);
      chequear("abort fase c5", fase, 0);
      chequear("abort ocupado c5", ocupado, 1);
      paso();
      chequear("abort fase c6", fase, 1);
      chequear("abort tiempo c6", bus.tiempo, 5);
      paso();
      parar = 1'b1;
      paso();
      parar = 1'b0;
      chequear("abort en c8", bus.EN_cuenta, 0);
      chequear("abort ocupado c8", ocupado, 0);
      chequear("abort fin c8", fin, 0);
      paso();
      chequear("abort cuenta c9", bus.cuenta, 0);
      medir(20, fin_c, n_a, n_b, max_a, sum_b, n_fin);
      chequear("abort no fin", n_fin, 0);
      chequear("abort no en", n_a + n_b, 0);

      // Async reset mid FASE_A
      lanzar(10, 1, 1);
      paso(); paso();
      #2 reset = 1'b0;
      #1;
      chequear("arst en", bus.EN_cuenta, 0);
      chequear("arst ocupado", ocupado, 0);
      chequear("arst tiempo", bus.tiempo, 0);
      chequear("arst fin", fin, 0);
      #2 reset = 1'b1;
      paso(); paso(); paso();
      chequear("arst ocupado after", ocupado, 0);
      chequear("arst en after", bus.EN_cuenta, 0);

`ifdef SECUENCIADOR_CICLO_CHECK_EN
      // Stuck counter: shadow mismatch aborts and locks out start
      atasco = 1'b1;
      lanzar(6, 2, 1);
      paso();
      chequear("chk error", error, 1);
      chequear("chk ocupado", ocupado, 0);
      chequear("chk en", bus.EN_cuenta, 0);
      atasco = 1'b0;
      paso();
      lanzar(6, 2, 1);
      chequear("chk start ignored", ocupado, 0);
      chequear("chk error sticky", error, 1);
      #2 reset = 1'b0;
      #2 reset = 1'b1;
      paso();
      chequear("chk error cleared", error, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
